// File: rtl/pico16a_lcd_ctrl.sv
// pico16a_lcd_ctrl: sequencer for the DE2 16x2 HD44780 character LCD.
// After reset it runs the power-on init sequence by itself. It then accepts
// single command/data bytes from the CPU over a req/ack handshake and drives
// the RS/DATA setup, the EN pulse and the post-write settle delay.
//
// Ports
//   clk        system clock
//   reset      asynchronous reset, active-high
//   wr_req     requester has a byte, held until wr_ack
//   wr_rs      0 = command, 1 = character data
//   wr_data    byte to write
//   wr_ack     one-cycle pulse: byte accepted and latched
//   busy       1 unless idle with init complete (combinational from state)
//   init_done  init sequence finished, stays 1 until reset
//   LCD_ON     LCD power, constant 1
//   LCD_BLON   backlight, constant 1
//   LCD_RW     constant 0 (write only)
//   LCD_EN     LCD enable strobe
//   LCD_RS     LCD register select
//   LCD_DATA   LCD data bus
module pico16a_lcd_ctrl #(
  parameter int unsigned INIT_WAIT_CYC = 750000,
  parameter int unsigned EN_HIGH_CYC   = 25,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned CLR_WAIT_CYC  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned MAX_AB  = (INIT_WAIT_CYC > EN_HIGH_CYC) ? INIT_WAIT_CYC : EN_HIGH_CYC;
  localparam int unsigned MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned IW      = 3;

  // Terminal counts: counters run 0..N-1 and never wrap.
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT_CYC - 1);
  localparam logic [CW-1:0] EN_LAST   = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(5);

  typedef enum logic [2:0] {
    PWR_WAIT  = 3'd0,
    INIT_LOAD = 3'd1,
    IDLE      = 3'd2,
    SETUP     = 3'd3,
    EN_HI     = 3'd4,
    HOLD      = 3'd5,
    SETTLE    = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          init_done_nxt;
  logic          wr_ack_nxt;
  logic          lcd_en_nxt;
  logic          lcd_rs_nxt;
  logic [7:0]    lcd_data_nxt;
  logic [7:0]    rom_byte;
  logic [CW-1:0] settle_last;

  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;
  assign LCD_RW   = 1'b0;
  assign busy     = !((state == IDLE) && init_done);

  // Init command ROM: function set x3, display on, clear, entry mode.
  always_comb begin
    rom_byte = 8'h00;
    case (idx)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:             rom_byte = 8'h0C;
      3'd4:             rom_byte = 8'h01;
      3'd5:             rom_byte = 8'h06;
      default:          rom_byte = 8'h00;
    endcase
  end

  // Clear and return-home need the long settle time.
  assign settle_last = (!LCD_RS && ((LCD_DATA == 8'h01) || (LCD_DATA == 8'h02)))
                       ? CLR_LAST : CMD_LAST;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= '0;
      init_done <= 1'b0;
      wr_ack    <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      init_done <= init_done_nxt;
      wr_ack    <= wr_ack_nxt;
      LCD_EN    <= lcd_en_nxt;
      LCD_RS    <= lcd_rs_nxt;
      LCD_DATA  <= lcd_data_nxt;
    end
  end

  // Next-state, cycle counter and init index.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    init_done_nxt = init_done;
    case (state)
      PWR_WAIT: begin
        if (cnt == INIT_LAST) begin
          state_nxt = INIT_LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      INIT_LOAD: state_nxt = SETUP;
      IDLE: begin
        if (wr_req) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = EN_HI;
        cnt_nxt   = '0;
      end
      EN_HI: begin
        if (cnt == EN_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
      SETTLE: begin
        if (cnt == settle_last) begin
          cnt_nxt = '0;
          if (init_done) begin
            state_nxt = IDLE;
          end else if (idx == IDX_LAST) begin
            state_nxt     = IDLE;
            init_done_nxt = 1'b1;
          end else begin
            state_nxt = INIT_LOAD;
            idx_nxt   = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = PWR_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Next values of the registered outputs; RS/DATA only change on SETUP entry.
  always_comb begin
    wr_ack_nxt   = 1'b0;
    lcd_en_nxt   = (state_nxt == EN_HI);
    lcd_rs_nxt   = LCD_RS;
    lcd_data_nxt = LCD_DATA;
    if ((state == IDLE) && wr_req) begin
      wr_ack_nxt   = 1'b1;
      lcd_rs_nxt   = wr_rs;
      lcd_data_nxt = wr_data;
    end else if (state == INIT_LOAD) begin
      lcd_rs_nxt   = 1'b0;
      lcd_data_nxt = rom_byte;
    end
  end

endmodule

// File: tb/tb_pico16a_lcd_ctrl.sv
// Self-checking bench for pico16a_lcd_ctrl with a timeline-based reference model.
module tb_pico16a_lcd_ctrl;

  localparam int P_INIT = 20;
  localparam int P_EN   = 3;
  localparam int P_CMD  = 10;
  localparam int P_CLR  = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_req = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ack, busy, init_done;
  logic       LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS;
  logic [7:0] LCD_DATA;

  pico16a_lcd_ctrl #(
    .INIT_WAIT_CYC(P_INIT),
    .EN_HIGH_CYC  (P_EN),
    .CMD_WAIT_CYC (P_CMD),
    .CLR_WAIT_CYC (P_CLR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_req   (wr_req),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .busy     (busy),
    .init_done(init_done),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom_tab [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Model: activity kind (0 power wait, 1 init write, 2 user write, 3 idle)
  // and t = cycles since that write's SETUP cycle (-1 = ROM load cycle).
  int         m_kind, m_t, m_idx;
  logic       m_rs;
  logic [7:0] m_byte;
  logic       exp_rs;
  logic [7:0] exp_data;

  int         cyc;
  logic       prev_en, prev_busy;
  logic [8:0] dut_log[$];
  logic [8:0] exp_log[$];
  int         en_rise[$];
  int         ack_cyc[$];
  int         busy_fall[$];

  logic [8:0] txq[$];
  bit         btb = 1'b0;
  int         gap = 0;

  function automatic int wait_for(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_CMD;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_t = 0; m_idx = 0;
    exp_rs = 1'b0; exp_data = 8'h00;
    prev_en = 1'b0; prev_busy = 1'b1;
    cyc = 0;
    dut_log.delete(); en_rise.delete(); ack_cyc.delete(); busy_fall.delete();
  endtask

  // One sample point: compare, record, drive next inputs, advance model.
  task automatic tick();
    logic        e_en, e_ack, e_busy, e_done;
    logic [15:0] act_v, exp_v;
    e_en   = (m_kind == 1 || m_kind == 2) && m_t >= 1 && m_t <= P_EN;
    e_ack  = (m_kind == 2) && (m_t == 0);
    e_busy = (m_kind != 3);
    e_done = (m_kind >= 2);
    act_v = {LCD_EN, wr_ack, busy, init_done, LCD_RS, LCD_DATA, LCD_ON, LCD_BLON, LCD_RW};
    exp_v = {e_en, e_ack, e_busy, e_done, exp_rs, exp_data, 1'b1, 1'b1, 1'b0};
    check("cycle{en,ack,busy,done,rs,data,on,blon,rw}", 32'(act_v), 32'(exp_v));

    if (LCD_EN && !prev_en) begin
      dut_log.push_back({LCD_RS, LCD_DATA});
      en_rise.push_back(cyc);
    end
    if (wr_ack) ack_cyc.push_back(cyc);
    if (!busy && prev_busy) busy_fall.push_back(cyc);
    prev_en = LCD_EN;
    prev_busy = busy;

    // Requester
    if (wr_req && wr_ack) begin
      void'(txq.pop_front());
      if (!(btb && txq.size() > 0)) begin
        wr_req = 1'b0;
        gap = $urandom_range(0, 4);
      end
    end
    if (!wr_req) begin
      if (gap > 0) gap--;
      else if (txq.size() > 0) wr_req = 1'b1;
    end
    if (wr_req) {wr_rs, wr_data} = txq[0];
    else begin
      wr_rs = 1'($urandom);
      wr_data = 8'($urandom);
    end

    // Model advance across the coming edge
    case (m_kind)
      0: begin
        m_t++;
        if (m_t == P_INIT) begin m_kind = 1; m_idx = 0; m_t = -1; end
      end
      1, 2: begin
        m_t++;
        if (m_t == 0) begin
          m_rs = 1'b0; m_byte = rom_tab[m_idx];
          exp_rs = m_rs; exp_data = m_byte;
        end else if (m_t == 2 + P_EN + wait_for(m_rs, m_byte)) begin
          if (m_kind == 1 && m_idx < 5) begin m_idx++; m_t = -1; end
          else m_kind = 3;
        end
      end
      default: begin
        if (wr_req) begin
          m_kind = 2; m_t = 0; m_rs = wr_rs; m_byte = wr_data;
          exp_rs = m_rs; exp_data = m_byte;
        end
      end
    endcase
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_outputs{en,ack,busy,done,rs,data}",
          32'({LCD_EN, wr_ack, busy, init_done, LCD_RS, LCD_DATA}),
          32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin step(); n++; end
    while (!(m_kind == 3 && txq.size() == 0 && !wr_req) && n < budget);
    check("idle_reached", 32'(n < budget), 32'd1);
    repeat (3) step();
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(dut_log.size()), 32'(exp_log.size()));
    foreach (exp_log[i])
      if (i < dut_log.size()) check(name, 32'(dut_log[i]), 32'(exp_log[i]));
  endtask

  task automatic expect_init_log();
    exp_log.delete();
    foreach (rom_tab[i]) exp_log.push_back({1'b0, rom_tab[i]});
  endtask

  task automatic send_one(input logic rs, input logic [7:0] d, input int span);
    dut_log.delete(); ack_cyc.delete(); busy_fall.delete();
    txq.push_back({rs, d});
    run_until_idle(200);
    check("ack_count", 32'(ack_cyc.size()), 32'd1);
    if (ack_cyc.size() == 1 && busy_fall.size() >= 1)
      check("busy_span", 32'(busy_fall[0] - ack_cyc[0]), 32'(span));
    else check("busy_span_present", 32'(busy_fall.size()), 32'd1);
    exp_log.delete(); exp_log.push_back({rs, d});
    check_log("write_byte");
  endtask

  initial begin
    int n;
    #2 reset = 1'b1;

    // 1: power-on init with no requests
    do_reset();
    run_until_idle(400);
    expect_init_log();
    check_log("init_rom");
    check("first_en_rise", 32'(en_rise.size() > 0 ? en_rise[0] : -1), 32'd22);
    if (en_rise.size() == 6) begin
      check("gap_after_0C", 32'(en_rise[4] - en_rise[3]), 32'd16);
      check("gap_after_01", 32'(en_rise[5] - en_rise[4]), 32'd36);
    end else check("en_rise_count", 32'(en_rise.size()), 32'd6);
    check("init_idle_cycle", 32'(busy_fall.size() > 0 ? busy_fall[0] : -1), 32'd136);

    // 2/3: single writes and settle lengths
    send_one(1'b1, 8'h41, 15);
    send_one(1'b0, 8'h01, 35);
    send_one(1'b1, 8'h01, 15);
    send_one(1'b0, 8'h02, 35);

    // 4: back-to-back "ABC"
    dut_log.delete(); ack_cyc.delete();
    btb = 1'b1;
    txq.push_back({1'b1, 8'h41}); txq.push_back({1'b1, 8'h42}); txq.push_back({1'b1, 8'h43});
    run_until_idle(300);
    btb = 1'b0;
    check("btb_ack_count", 32'(ack_cyc.size()), 32'd3);
    if (ack_cyc.size() == 3) begin
      check("btb_ack_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd16);
      check("btb_ack_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd16);
    end
    exp_log.delete();
    exp_log.push_back({1'b1, 8'h41}); exp_log.push_back({1'b1, 8'h42}); exp_log.push_back({1'b1, 8'h43});
    check_log("btb_abc");

    // 5: request held through init
    gap = 0;
    txq.push_back({1'b1, 8'h5A});
    do_reset();
    run_until_idle(400);
    check("first_ack_after_init", 32'(ack_cyc.size() > 0 ? ack_cyc[0] : -1), 32'd137);
    expect_init_log();
    exp_log.push_back({1'b1, 8'h5A});
    check_log("init_then_req");

    // 6: reset while LCD_EN is high during a user write
    txq.push_back({1'b1, 8'h77});
    n = 0;
    do begin step(); n++; end while (!LCD_EN && n < 100);
    check("en_seen", 32'(LCD_EN), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_write{en,done,busy}", 32'({LCD_EN, init_done, busy}), 32'({1'b0, 1'b0, 1'b1}));
    do_reset();
    run_until_idle(400);
    expect_init_log();
    check_log("reinit_rom");
    check("reinit_idle_cycle", 32'(busy_fall.size() > 0 ? busy_fall[0] : -1), 32'd136);

    // Random traffic
    dut_log.delete();
    exp_log.delete();
    for (int i = 0; i < 40; i++) begin
      logic       rs;
      logic [7:0] d;
      rs = 1'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      txq.push_back({rs, d});
      exp_log.push_back({rs, d});
    end
    btb = 1'b1;
    run_until_idle(4000);
    btb = 1'b0;
    check_log("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
